// File: rtl/writeback_arbiter_pkg.sv
// Shared constants for the writeback arbiter: default widths, result-source ids
// and the hard-wired zero register index.
package writeback_arbiter_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int REG_ZERO       = 0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LOAD = 2'd2,
    SRC_MUL  = 2'd3
  } src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard: one bit per register with an outstanding long-latency result.
// A set and a clear of the same bit in one cycle resolve to set; r0 never reads busy.
module wb_scoreboard
  import writeback_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       set_valid,
  input  logic [ADDR_WIDTH-1:0]      set_target,
  input  logic                       clr_valid,
  input  logic [ADDR_WIDTH-1:0]      clr_target,
  output logic [2**ADDR_WIDTH-1:0]   busy_mask
);

  logic [2**ADDR_WIDTH-1:0] mask_next;

  // Clear first, then set, so a newly issued op on the same register wins.
  always_comb begin
    mask_next = busy_mask;
    if (clr_valid) mask_next[clr_target] = 1'b0;
    if (set_valid) mask_next[set_target] = 1'b1;
    mask_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_mask <= '0;
    else     busy_mask <= mask_next;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU, load and mul/div results onto the register file's single write port
// and tracks registers with outstanding long-latency results.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     AluValid,
  input  logic [ADDR_WIDTH-1:0]    AluTarget,
  input  logic [DATA_WIDTH-1:0]    AluData,
  input  logic                     LoadValid,
  output logic                     LoadReady,
  input  logic [ADDR_WIDTH-1:0]    LoadTarget,
  input  logic [DATA_WIDTH-1:0]    LoadData,
  input  logic                     MulValid,
  output logic                     MulReady,
  input  logic [ADDR_WIDTH-1:0]    MulTarget,
  input  logic [DATA_WIDTH-1:0]    MulData,
  input  logic                     IssueValid,
  input  logic [ADDR_WIDTH-1:0]    IssueTarget,
  output logic                     WriteEnable,
  output logic [ADDR_WIDTH-1:0]    WriteTarget,
  output logic [DATA_WIDTH-1:0]    WriteData,
  output logic [2**ADDR_WIDTH-1:0] BusyMask
);

  src_e                  sel_src_p0;
  src_e                  last_grant;
  logic [ADDR_WIDTH-1:0] sel_target_p0;
  logic [DATA_WIDTH-1:0] sel_data_p0;
  logic                  vld_p0;
  logic                  write_p0;

  // Stage 0: source selection (ALU first, then round-robin between load and mul/div).
  always_comb begin
    sel_src_p0 = SRC_NONE;
    if (!Reset) begin
      if (AluValid)                   sel_src_p0 = SRC_ALU;
      else if (LoadValid && MulValid) sel_src_p0 = (last_grant == SRC_LOAD) ? SRC_MUL : SRC_LOAD;
      else if (LoadValid)             sel_src_p0 = SRC_LOAD;
      else if (MulValid)              sel_src_p0 = SRC_MUL;
    end
  end

  always_comb begin
    sel_target_p0 = '0;
    sel_data_p0   = '0;
    case (sel_src_p0)
      SRC_ALU:  begin sel_target_p0 = AluTarget;  sel_data_p0 = AluData;  end
      SRC_LOAD: begin sel_target_p0 = LoadTarget; sel_data_p0 = LoadData; end
      SRC_MUL:  begin sel_target_p0 = MulTarget;  sel_data_p0 = MulData;  end
      default:  begin sel_target_p0 = '0;         sel_data_p0 = '0;       end
    endcase
  end

  assign LoadReady = (sel_src_p0 == SRC_LOAD);
  assign MulReady  = (sel_src_p0 == SRC_MUL);
  assign vld_p0    = (sel_src_p0 != SRC_NONE);
  // r0 results are consumed but never reach the register file.
  assign write_p0  = vld_p0 && (sel_target_p0 != ADDR_WIDTH'(REG_ZERO));

  // Stage 1: registered write port.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      WriteEnable <= 1'b0;
      WriteTarget <= '0;
      WriteData   <= '0;
      last_grant  <= SRC_LOAD;
    end else begin
      WriteEnable <= write_p0;
      if (write_p0) begin
        WriteTarget <= sel_target_p0;
        WriteData   <= sel_data_p0;
      end
      if (LoadReady || MulReady) last_grant <= sel_src_p0;
    end
  end

  wb_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk        (Clock),
    .rst        (Reset),
    .set_valid  (IssueValid),
    .set_target (IssueTarget),
    .clr_valid  (LoadReady || MulReady),
    .clr_target (sel_target_p0),
    .busy_mask  (BusyMask)
  );

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vector table followed by protocol-respecting
// random traffic checked against a cycle-level reference model.
module tb_writeback_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        AluValid;
  logic [4:0]  AluTarget;
  logic [31:0] AluData;
  logic        LoadValid;
  logic        LoadReady;
  logic [4:0]  LoadTarget;
  logic [31:0] LoadData;
  logic        MulValid;
  logic        MulReady;
  logic [4:0]  MulTarget;
  logic [31:0] MulData;
  logic        IssueValid;
  logic [4:0]  IssueTarget;
  logic        WriteEnable;
  logic [4:0]  WriteTarget;
  logic [31:0] WriteData;
  logic [31:0] BusyMask;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  writeback_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .Clock(Clock), .Reset(Reset),
    .AluValid(AluValid), .AluTarget(AluTarget), .AluData(AluData),
    .LoadValid(LoadValid), .LoadReady(LoadReady), .LoadTarget(LoadTarget), .LoadData(LoadData),
    .MulValid(MulValid), .MulReady(MulReady), .MulTarget(MulTarget), .MulData(MulData),
    .IssueValid(IssueValid), .IssueTarget(IssueTarget),
    .WriteEnable(WriteEnable), .WriteTarget(WriteTarget), .WriteData(WriteData),
    .BusyMask(BusyMask)
  );

  typedef struct {
    bit rst;
    bit av; logic [4:0] at; logic [31:0] ad;
    bit lv; logic [4:0] lt; logic [31:0] ld;
    bit mv; logic [4:0] mt; logic [31:0] md;
    bit iv; logic [4:0] it;
    bit elr; bit emr;
    bit ewe; bit cd; logic [4:0] ewt; logic [31:0] ewd;
    logic [31:0] ebusy;
  } vec_t;

  // Reference state: what the register-file port and scoreboard should look like.
  bit        m_last_mul;
  bit [31:0] m_busy;
  bit        m_we;
  bit [4:0]  m_wt;
  bit [31:0] m_wd;

  function automatic vec_t mk(bit rst,
                              bit av, logic [4:0] at, logic [31:0] ad,
                              bit lv, logic [4:0] lt, logic [31:0] ld,
                              bit mv, logic [4:0] mt, logic [31:0] md,
                              bit iv, logic [4:0] it,
                              bit elr, bit emr,
                              bit ewe, bit cd, logic [4:0] ewt, logic [31:0] ewd,
                              logic [31:0] ebusy);
    vec_t v;
    v.rst = rst; v.av = av; v.at = at; v.ad = ad;
    v.lv = lv; v.lt = lt; v.ld = ld; v.mv = mv; v.mt = mt; v.md = md;
    v.iv = iv; v.it = it; v.elr = elr; v.emr = emr;
    v.ewe = ewe; v.cd = cd; v.ewt = ewt; v.ewd = ewd; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input bit use_tbl, output bit lr, output bit mr);
    int         g;
    logic [4:0] tgt;
    logic [31:0] dat;
    Reset = v.rst;
    AluValid = v.av;   AluTarget = v.at;   AluData = v.ad;
    LoadValid = v.lv;  LoadTarget = v.lt;  LoadData = v.ld;
    MulValid = v.mv;   MulTarget = v.mt;   MulData = v.md;
    IssueValid = v.iv; IssueTarget = v.it;
    #1;
    // 0 none, 1 alu, 2 load, 3 mul
    if (v.rst)             g = 0;
    else if (v.av)         g = 1;
    else if (v.lv && v.mv) g = m_last_mul ? 2 : 3;
    else if (v.lv)         g = 2;
    else if (v.mv)         g = 3;
    else                   g = 0;
    lr = (g == 2);
    mr = (g == 3);
    if (use_tbl) begin
      chk("load_ready", 32'(LoadReady), 32'(v.elr));
      chk("mul_ready",  32'(MulReady),  32'(v.emr));
    end else begin
      chk("load_ready", 32'(LoadReady), 32'(lr));
      chk("mul_ready",  32'(MulReady),  32'(mr));
    end
    tgt = (g == 1) ? v.at : (g == 2) ? v.lt : v.mt;
    dat = (g == 1) ? v.ad : (g == 2) ? v.ld : v.md;
    if (v.rst) begin
      m_we = 0; m_wt = 0; m_wd = 0; m_busy = 0; m_last_mul = 0;
    end else begin
      m_we = (g != 0) && (tgt != 0);
      if (m_we) begin m_wt = tgt; m_wd = dat; end
      if (g >= 2) begin
        m_busy[tgt] = 1'b0;
        m_last_mul = (g == 3);
      end
      if (v.iv) m_busy[v.it] = 1'b1;
      m_busy[0] = 1'b0;
    end
    @(posedge Clock); #1;
    if (use_tbl) begin
      chk("write_enable", 32'(WriteEnable), 32'(v.ewe));
      if (v.cd) begin
        chk("write_target", 32'(WriteTarget), 32'(v.ewt));
        chk("write_data",   WriteData,        v.ewd);
      end
      chk("busy_mask", BusyMask, v.ebusy);
    end else begin
      chk("write_enable", 32'(WriteEnable), 32'(m_we));
      chk("write_target", 32'(WriteTarget), 32'(m_wt));
      chk("write_data",   WriteData,        m_wd);
      chk("busy_mask",    BusyMask,         m_busy);
    end
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    bit   lr, mr;
    bit   l_hold, m_hold;
    logic [4:0]  lt_r, mt_r;
    logic [31:0] ld_r, md_r;

    m_last_mul = 0; m_busy = 0; m_we = 0; m_wt = 0; m_wd = 0;

    //               rst av at  ad            lv lt ld        mv mt ld        iv it  lr mr we cd wt  wd            busy
    tbl.push_back(mk(1, 0, 0,  0,            0, 0, 0,        0, 0, 0,        0, 0,  0, 0, 0, 1, 0,  0,            0));
    tbl.push_back(mk(1, 0, 0,  0,            1, 3, 32'h33,   1, 4, 32'h44,   1, 9,  0, 0, 0, 1, 0,  0,            0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0, 0,        0, 0, 0,        0, 0,  0, 0, 0, 0, 0,  0,            0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0, 0,        0, 0, 0,        0, 0,  0, 0, 0, 0, 0,  0,            0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0, 0,        0, 0, 0,        0, 0,  0, 0, 0, 0, 0,  0,            0));
    tbl.push_back(mk(0, 1, 5,  32'hDEADBEEF, 0, 0, 0,        0, 0, 0,        0, 0,  0, 0, 1, 1, 5,  32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 1, 6,  32'h22,       1, 7, 32'h11,   0, 0, 0,        0, 0,  0, 0, 1, 1, 6,  32'h22,       0));
    tbl.push_back(mk(0, 0, 0,  0,            1, 7, 32'h11,   0, 0, 0,        0, 0,  1, 0, 1, 1, 7,  32'h11,       0));
    tbl.push_back(mk(0, 0, 0,  0,            1, 3, 32'h33,   1, 4, 32'h44,   0, 0,  0, 1, 1, 1, 4,  32'h44,       0));
    tbl.push_back(mk(0, 0, 0,  0,            1, 3, 32'h33,   1, 4, 32'h44,   0, 0,  1, 0, 1, 1, 3,  32'h33,       0));
    tbl.push_back(mk(0, 0, 0,  0,            1, 3, 32'h33,   1, 4, 32'h44,   0, 0,  0, 1, 1, 1, 4,  32'h44,       0));
    tbl.push_back(mk(0, 0, 0,  0,            1, 3, 32'h33,   1, 4, 32'h44,   0, 0,  1, 0, 1, 1, 3,  32'h33,       0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0, 0,        0, 0, 0,        1, 9,  0, 0, 0, 0, 0,  0,            32'h200));
    tbl.push_back(mk(0, 0, 0,  0,            1, 9, 32'h99,   0, 0, 0,        1, 9,  1, 0, 1, 1, 9,  32'h99,       32'h200));
    tbl.push_back(mk(0, 0, 0,  0,            1, 9, 32'h9A,   0, 0, 0,        0, 0,  1, 0, 1, 1, 9,  32'h9A,       0));
    tbl.push_back(mk(0, 0, 0,  0,            1, 0, 32'h55,   0, 0, 0,        0, 0,  1, 0, 0, 0, 0,  0,            0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0, 0,        0, 0, 0,        1, 0,  0, 0, 0, 0, 0,  0,            0));
    tbl.push_back(mk(0, 0, 0,  0,            1, 2, 32'h77,   0, 0, 0,        1, 9,  1, 0, 1, 1, 2,  32'h77,       32'h200));
    tbl.push_back(mk(1, 0, 0,  0,            0, 0, 0,        0, 0, 0,        0, 0,  0, 0, 0, 1, 0,  0,            0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0, 0,        1, 10, 32'hA0,  1, 11, 0, 1, 1, 1, 10, 32'hA0,       32'h800));
    tbl.push_back(mk(0, 0, 0,  0,            1, 3, 32'h33,   1, 4, 32'h44,   0, 0,  1, 0, 1, 1, 3,  32'h33,       32'h800));
    tbl.push_back(mk(0, 1, 11, 32'hCAFE,     0, 0, 0,        1, 4, 32'h44,   0, 0,  0, 0, 1, 1, 11, 32'hCAFE,     32'h800));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0, 0,        1, 4, 32'h44,   0, 0,  0, 1, 1, 1, 4,  32'h44,       32'h800));

    foreach (tbl[i]) run(tbl[i], 1'b1, lr, mr);

    // Random traffic; offers stay stable until the model says they were taken.
    l_hold = 0; m_hold = 0;
    lt_r = 0; mt_r = 0; ld_r = 0; md_r = 0;
    for (int n = 0; n < 600; n++) begin
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.rst = ($urandom_range(0, 59) == 0);
      v.av  = ($urandom_range(0, 3) == 0);
      v.at  = 5'($urandom_range(0, 31));
      v.ad  = $urandom;
      if (!l_hold && ($urandom_range(0, 1) == 1)) begin
        l_hold = 1; lt_r = 5'($urandom_range(0, 31)); ld_r = $urandom;
      end
      if (!m_hold && ($urandom_range(0, 1) == 1)) begin
        m_hold = 1; mt_r = 5'($urandom_range(0, 31)); md_r = $urandom;
      end
      v.lv = l_hold; v.lt = lt_r; v.ld = ld_r;
      v.mv = m_hold; v.mt = mt_r; v.md = md_r;
      v.iv = ($urandom_range(0, 2) == 0);
      v.it = 5'($urandom_range(0, 31));
      run(v, 1'b0, lr, mr);
      if (lr) l_hold = 0;
      if (mr) m_hold = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
